// File: rtl/control_sequencer.sv
// Hardwired T0..T6 step sequencer for the 32-bit datapath.
// Decodes IR[31:27]: fetch, register ALU, unary, mul/div, nop, halt.
module control_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        Run,
  input  logic [31:0] IR,
  input  logic        Mem_rdy,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        LOin,
  output logic        HIin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  ALU_sel,
  output logic        Done,
  output logic        Mem_err,
  output logic        Illegal
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_HALT
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [4:0] op;
  logic       is_arith, is_md, is_un;
  logic       is_nop, is_halt, is_bin;
  logic       unused_ir;
  state_e     eoi;

  assign op        = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_bin    = is_arith | is_md;
  assign eoi       = Run ? S_T0 : S_IDLE;

  always_comb begin
    is_arith = 1'b0;
    is_md    = 1'b0;
    is_un    = 1'b0;
    is_nop   = 1'b0;
    is_halt  = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010: is_arith = 1'b1;
      5'b01111, 5'b10000: is_md = 1'b1;
      5'b10001, 5'b10010: is_un = 1'b1;
      5'b11010:           is_nop = 1'b1;
      5'b11011:           is_halt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    done_d   = done_q;
    err_d    = err_q;
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    Rout     = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Rin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    ALU_sel  = 5'd0;
    Illegal  = 1'b0;
    unique case (state_q)
      S_IDLE: if (Run) state_d = S_T0;
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // wait for memory; the Nth idle cycle gives up
        if (Mem_rdy) begin
          state_d = S_T2;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        unique case (1'b1)
          is_bin: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            Yin     = 1'b1;
            state_d = S_T4;
          end
          is_un: begin
            Grb     = 1'b1;
            Rout    = 1'b1;
            Zin     = 1'b1;
            ALU_sel = op;
            state_d = S_T4;
          end
          is_nop: state_d = eoi;
          is_halt: begin
            done_d  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            Illegal = 1'b1;
            state_d = eoi;
          end
        endcase
      end
      S_T4: begin
        if (is_bin) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_sel = op;
          state_d = S_T5;
        end else begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = eoi;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = eoi;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = eoi;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign Done    = done_q;
  assign Mem_err = err_q;

endmodule
